// File: rtl/seq_pkg.sv
// Shared definitions for the serial word path: word width and serializer states.
package seq_pkg;

  localparam int WORD_W = 7;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/word_serializer_fifo.sv
// Small circular word buffer with occupancy count, feeding the serializer.
module word_fifo
  import seq_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks net push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/word_serializer.sv
// Buffers parallel words and shifts them out MSB-first with bit index and framing flags.
module word_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_word,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       ser_bit,
  output logic                       ser_valid,
  input  logic                       ser_ready,
  output logic [$clog2(WIDTH)-1:0]   bit_idx,
  output logic                       word_first,
  output logic                       word_last,
  output logic [$clog2(DEPTH):0]     words_pend
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);

  ser_state_e       state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [IDX_W-1:0] bit_idx_q;

  logic             fifo_push;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;

  // in_ready comes straight from the registered occupancy, so a pop on the
  // same edge never lets a push into a full buffer.
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  assign fifo_pop  = !fifo_empty &&
                     ((state_q == IDLE) || (ser_ready && (bit_idx_q == '0)));

  word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (in_word),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (words_pend)
  );

  // Serializer FSM: loads the head word, shifts left on each beat, and reloads
  // on the last bit when another word is waiting so words run back-to-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= TOP_IDX;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q   <= SHIFT;
            shreg_q   <= fifo_rdata;
            bit_idx_q <= TOP_IDX;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            if (bit_idx_q != '0) begin
              bit_idx_q <= bit_idx_q - IDX_W'(1);
              shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
            end else if (!fifo_empty) begin
              shreg_q   <= fifo_rdata;
              bit_idx_q <= TOP_IDX;
            end else begin
              state_q   <= IDLE;
              bit_idx_q <= TOP_IDX;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          bit_idx_q <= TOP_IDX;
        end
      endcase
    end
  end

  // The current bit always sits at the MSB of the shift register.
  assign ser_bit    = shreg_q[WIDTH-1];
  assign ser_valid  = (state_q == SHIFT);
  assign bit_idx    = bit_idx_q;
  assign word_first = ser_valid && (bit_idx_q == TOP_IDX);
  assign word_last  = ser_valid && (bit_idx_q == '0);

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: accepted words expand into expected bit beats in a
// queue; a monitor pops and compares on every serial beat.
module tb_word_serializer;

  localparam int W = 7;
  localparam int D = 2;

  typedef struct {
    logic b;
    int   idx;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_word;
  logic         in_valid;
  logic         in_ready;
  logic         ser_bit;
  logic         ser_valid;
  logic         ser_ready;
  logic [2:0]   bit_idx;
  logic         word_first;
  logic         word_last;
  logic [1:0]   words_pend;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  beat_t exp_q[$];

  word_serializer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .bit_idx    (bit_idx),
    .word_first (word_first),
    .word_last  (word_last),
    .words_pend (words_pend)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: an accepted word becomes WIDTH beats, MSB first.
  always @(negedge clk) begin
    beat_t e;
    if (reset && in_valid && in_ready) begin
      for (int i = W - 1; i >= 0; i--) begin
        e.b   = in_word[i];
        e.idx = i;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: every beat consumes one expected entry.
  always @(negedge clk) begin
    beat_t e;
    if (reset && ser_valid && ser_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ser_bit", int'(ser_bit), int'(e.b));
        chk("bit_idx", int'(bit_idx), e.idx);
        chk("word_first", int'(word_first), int'(e.idx == W - 1));
        chk("word_last", int'(word_last), int'(e.idx == 0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w, output int acc_cyc);
    bit acc;
    acc = 1'b0;
    in_word  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    ser_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !ser_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", int'(done), 1);
  endtask

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int          kc;
    int          rel;
    int          nvalid;
    int          first_i;
    int          last_i;
    int          wraps;
    int          prev_idx;
    int          sent;
    bit          found;
    bit          acc;
    logic [W-1:0] w;
    logic         hb;

    reset     = 1'b0;
    in_word   = '0;
    in_valid  = 1'b0;
    ser_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ser_valid", int'(ser_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_words_pend", int'(words_pend), 0);
    chk("rst_bit_idx", int'(bit_idx), W - 1);
    chk("rst_ser_bit", int'(ser_bit), 0);
    reset = 1'b1;
    tick();

    // 1: single word, latency and return to idle
    ser_ready = 1'b1;
    push_word(7'b1011001, kc);
    @(negedge clk);
    chk("lat_edge_k", int'(ser_valid), 0);
    @(negedge clk);
    chk("lat_edge_k1", int'(ser_valid), 1);
    repeat (7) @(negedge clk);
    chk("idle_after_word", int'(ser_valid), 0);

    // 2: back-to-back words, no bubble, one wrap
    tick();
    in_word  = 7'h55;
    in_valid = 1'b1;
    tick();
    in_word  = 7'h2A;
    tick();
    in_valid = 1'b0;
    nvalid = 0; first_i = -1; last_i = -1; wraps = 0; prev_idx = -1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (ser_valid) begin
        nvalid++;
        if (first_i < 0) first_i = i;
        last_i = i;
        if (prev_idx == 0 && bit_idx == 3'd6) wraps++;
        prev_idx = int'(bit_idx);
      end
    end
    chk("b2b_valid_count", nvalid, 14);
    chk("b2b_no_bubble", last_i - first_i + 1, 14);
    chk("b2b_wraps", wraps, 1);

    // 3: stall at bit_idx 3
    tick();
    w = 7'($urandom);
    push_word(w, kc);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ser_valid && bit_idx == 3'd3) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("reach_idx3", int'(found), 1);
    ser_ready = 1'b0;
    hb = w[3];
    chk("hold_bit_start", int'(ser_bit), int'(hb));
    repeat (3) begin
      @(negedge clk);
      chk("hold_bit", int'(ser_bit), int'(hb));
      chk("hold_idx", int'(bit_idx), 3);
      chk("hold_valid", int'(ser_valid), 1);
    end
    tick();
    ser_ready = 1'b1;
    wait_drain();

    // 4: fill with ser_ready low, fourth word stalls until first completes
    tick();
    ser_ready = 1'b0;
    push_word(7'($urandom), kc);
    push_word(7'($urandom), kc);
    push_word(7'($urandom), kc);
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_words_pend", int'(words_pend), 2);
    chk("full_loaded_idx", int'(bit_idx), W - 1);
    w = 7'($urandom);
    in_word  = w;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    chk("stall_words_pend", int'(words_pend), 2);
    tick();
    ser_ready = 1'b1;
    rel = cyc;
    push_word(w, kc);
    chk("stall_release_cycles", kc - rel, 8);
    wait_drain();
    chk("drained_words_pend", int'(words_pend), 0);

    // 5: reset mid-word with one word buffered
    tick();
    ser_ready = 1'b1;
    in_word   = 7'($urandom);
    in_valid  = 1'b1;
    tick();
    in_word   = 7'($urandom);
    tick();
    in_valid  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ser_valid && bit_idx == 3'd2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("reach_idx2", int'(found), 1);
    chk("pre_rst_words_pend", int'(words_pend), 1);
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_ser_valid", int'(ser_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_words_pend", int'(words_pend), 0);
    chk("mid_rst_bit_idx", int'(bit_idx), W - 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_quiet", int'(ser_valid), 0);
    end

    // Random traffic with random back-pressure
    tick();
    sent = 0;
    for (int c = 0; c < 4000 && sent < 40; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
      if (!in_valid && sent < 40 && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        in_word  = 7'($urandom);
      end
      ser_ready = ($urandom_range(3) != 0);
    end
    in_valid = 1'b0;
    chk("rand_words_sent", sent, 40);
    wait_drain();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_words_pend", int'(words_pend), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
